// File: rtl/jpeg_pkg.sv
// Shared types and zig-zag tables for the JPEG
// zig-zag / run-length token stage.
package jpeg_pkg;

  localparam int COEF_W = 11;
  localparam int RUN_W  = 4;

  localparam logic [2:0] ZZ_ROW [64] = '{
    3'd0, 3'd0, 3'd1, 3'd2, 3'd1, 3'd0, 3'd0, 3'd1,
    3'd2, 3'd3, 3'd4, 3'd3, 3'd2, 3'd1, 3'd0, 3'd0,
    3'd1, 3'd2, 3'd3, 3'd4, 3'd5, 3'd6, 3'd5, 3'd4,
    3'd3, 3'd2, 3'd1, 3'd0, 3'd0, 3'd1, 3'd2, 3'd3,
    3'd4, 3'd5, 3'd6, 3'd7, 3'd7, 3'd6, 3'd5, 3'd4,
    3'd3, 3'd2, 3'd1, 3'd2, 3'd3, 3'd4, 3'd5, 3'd6,
    3'd7, 3'd7, 3'd6, 3'd5, 3'd4, 3'd3, 3'd4, 3'd5,
    3'd6, 3'd7, 3'd7, 3'd6, 3'd5, 3'd6, 3'd7, 3'd7
  };

  localparam logic [2:0] ZZ_COL [64] = '{
    3'd0, 3'd1, 3'd0, 3'd0, 3'd1, 3'd2, 3'd3, 3'd2,
    3'd1, 3'd0, 3'd0, 3'd1, 3'd2, 3'd3, 3'd4, 3'd5,
    3'd4, 3'd3, 3'd2, 3'd1, 3'd0, 3'd0, 3'd1, 3'd2,
    3'd3, 3'd4, 3'd5, 3'd6, 3'd7, 3'd6, 3'd5, 3'd4,
    3'd3, 3'd2, 3'd1, 3'd0, 3'd1, 3'd2, 3'd3, 3'd4,
    3'd5, 3'd6, 3'd7, 3'd7, 3'd6, 3'd5, 3'd4, 3'd3,
    3'd2, 3'd3, 3'd4, 3'd5, 3'd6, 3'd7, 3'd7, 3'd6,
    3'd5, 3'd4, 3'd5, 3'd6, 3'd7, 3'd7, 3'd6, 3'd7
  };

  typedef struct packed {
    logic [RUN_W-1:0]  run;
    logic [COEF_W-1:0] level;
    logic              dc;
    logic              eob;
    logic              last;
  } tok_t;

  typedef enum logic [1:0] {
    IDLE,
    DC,
    SCAN,
    EOB
  } state_t;

endpackage

// File: rtl/zigzag_rle_if.sv
// Block-in / token-out handshake bundle for
// the zig-zag run-length stage.
interface zigzag_rle_if;
  import jpeg_pkg::*;

  logic                             in_valid;
  logic                             in_ready;
  logic [7:0][7:0][COEF_W-1:0]      in_matrix;
  logic                             out_valid;
  logic                             out_ready;
  logic [RUN_W-1:0]                 out_run;
  logic [COEF_W-1:0]                out_level;
  logic                             out_dc;
  logic                             out_eob;
  logic                             out_last;

  modport master (
    output in_valid, in_matrix, out_ready,
    input  in_ready, out_valid, out_run,
    input  out_level, out_dc, out_eob, out_last
  );

  modport slave (
    input  in_valid, in_matrix, out_ready,
    output in_ready, out_valid, out_run,
    output out_level, out_dc, out_eob, out_last
  );

endinterface

// File: rtl/zigzag_lut.sv
// Zig-zag index to (row, col) lookup.
// Purely combinational.
module zigzag_lut
  import jpeg_pkg::*;
(
  input  logic [5:0] idx,
  output logic [2:0] row,
  output logic [2:0] col
);

  assign row = ZZ_ROW[idx];
  assign col = ZZ_COL[idx];

endmodule

// File: rtl/zigzag_rle.sv
// Captures one 8x8 block, scans it in zig-zag
// order and emits (run, level) tokens with DC/ZRL/EOB.
module zigzag_rle
  import jpeg_pkg::*;
(
  input  logic         clk,
  input  logic         rst_n,
  zigzag_rle_if.slave  bus
);

  typedef logic [7:0][7:0][COEF_W-1:0] mat_t;

  state_t            state_q, state_d;
  mat_t              buf_q, buf_d;
  logic [5:0]        idx_q, idx_d;
  logic [5:0]        lnz_q, lnz_d;
  logic [RUN_W-1:0]  run_q, run_d;
  logic              valid_q, valid_d;
  tok_t              tok_q, tok_d;

  logic [63:1]       nz;
  logic [5:0]        lnz_in;
  logic [2:0]        srow, scol;
  logic [COEF_W-1:0] coef;
  logic              hs;
  logic              past, skip, emit;

  genvar g;
  generate
    for (g = 1; g < 64; g++) begin : g_nz
      logic [2:0] r, c;
      zigzag_lut u_lut (
        .idx (6'(g)),
        .row (r),
        .col (c)
      );
      assign nz[g] = |bus.in_matrix[r][c];
    end
  endgenerate

  // highest nonzero zig-zag index of the incoming block
  always_comb begin
    lnz_in = '0;
    for (int i = 1; i < 64; i++) begin
      if (nz[i]) lnz_in = 6'(i);
    end
  end

  zigzag_lut u_scan (
    .idx (idx_q),
    .row (srow),
    .col (scol)
  );

  assign coef = buf_q[srow][scol];
  assign hs   = valid_q && bus.out_ready;

  assign past = idx_q > lnz_q;
  assign skip = !past && (coef == '0)
             && (run_q != 4'd15);
  assign emit = !past && !skip;

  assign bus.in_ready  = (state_q == IDLE);
  assign bus.out_valid = valid_q;
  assign bus.out_run   = tok_q.run;
  assign bus.out_level = tok_q.level;
  assign bus.out_dc    = tok_q.dc;
  assign bus.out_eob   = tok_q.eob;
  assign bus.out_last  = tok_q.last;

  always_comb begin
    state_d = state_q;
    buf_d   = buf_q;
    idx_d   = idx_q;
    lnz_d   = lnz_q;
    run_d   = run_q;
    valid_d = valid_q;
    tok_d   = tok_q;
    case (state_q)
      IDLE: begin
        if (bus.in_valid) begin
          buf_d       = bus.in_matrix;
          lnz_d       = lnz_in;
          idx_d       = 6'd1;
          run_d       = '0;
          state_d     = DC;
          valid_d     = 1'b1;
          tok_d       = '0;
          tok_d.level = bus.in_matrix[0][0];
          tok_d.dc    = 1'b1;
        end
      end
      DC: begin
        if (hs) begin
          valid_d = 1'b0;
          state_d = SCAN;
          if (lnz_q == '0) begin
            state_d    = EOB;
            valid_d    = 1'b1;
            tok_d      = '0;
            tok_d.eob  = 1'b1;
            tok_d.last = 1'b1;
          end
        end
      end
      SCAN: begin
        if (valid_q) begin
          if (bus.out_ready) begin
            valid_d = 1'b0;
            run_d   = '0;
            idx_d   = idx_q + 6'd1;
            if (tok_q.last) state_d = IDLE;
          end
        end else begin
          unique case (1'b1)
            past: begin
              state_d    = EOB;
              valid_d    = 1'b1;
              tok_d      = '0;
              tok_d.eob  = 1'b1;
              tok_d.last = 1'b1;
            end
            skip: begin
              run_d = run_q + 4'd1;
              idx_d = idx_q + 6'd1;
            end
            // ZRL falls out here too: run 15, coef 0
            emit: begin
              valid_d     = 1'b1;
              tok_d       = '0;
              tok_d.run   = run_q;
              tok_d.level = coef;
              tok_d.last  = (idx_q == 6'd63);
            end
          endcase
        end
      end
      EOB: begin
        if (hs) begin
          valid_d = 1'b0;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      buf_q   <= '0;
      idx_q   <= '0;
      lnz_q   <= '0;
      run_q   <= '0;
      valid_q <= 1'b0;
      tok_q   <= '0;
    end else begin
      state_q <= state_d;
      buf_q   <= buf_d;
      idx_q   <= idx_d;
      lnz_q   <= lnz_d;
      run_q   <= run_d;
      valid_q <= valid_d;
      tok_q   <= tok_d;
    end
  end

endmodule

// File: tb/tb_zigzag_rle.sv
// Scoreboard bench for zigzag_rle: directed blocks,
// stall patterns and a mid-block reset.
module tb_zigzag_rle;
  import jpeg_pkg::*;

  typedef logic [7:0][7:0][COEF_W-1:0] mat_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  zigzag_rle_if bus ();

  zigzag_rle u_dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  tok_t exp_q[$];
  int   total = 0;
  int   bad = 0;
  int   popped = 0;
  int   mode = 0;
  bit   chk_rdy = 0;
  bit   prev_stall = 0;
  tok_t prev_tok;

  function automatic tok_t tk(int r, int l,
      bit d = 0, bit e = 0, bit la = 0);
    tok_t t;
    t.run   = r[RUN_W-1:0];
    t.level = l[COEF_W-1:0];
    t.dc    = d;
    t.eob   = e;
    t.last  = la;
    return t;
  endfunction

  function automatic tok_t cur();
    tok_t t;
    t.run   = bus.out_run;
    t.level = bus.out_level;
    t.dc    = bus.out_dc;
    t.eob   = bus.out_eob;
    t.last  = bus.out_last;
    return t;
  endfunction

  task automatic chk(string n, logic [31:0] act,
      logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", n, act, exp);
    end
  endtask

  // ready pattern: 0 always, 1 toggle, 2 random
  initial bus.out_ready = 1'b1;
  always begin
    @(posedge clk);
    #1;
    case (mode)
      1: bus.out_ready = ~bus.out_ready;
      2: bus.out_ready = 1'($urandom_range(0, 1));
      default: bus.out_ready = 1'b1;
    endcase
  end

  // monitor: compare each accepted token with the queue head
  always @(negedge clk) begin
    if (!rst_n) begin
      prev_stall = 0;
      chk_rdy = 0;
    end else begin
      if (chk_rdy) begin
        chk("in_ready_after_last", 32'(bus.in_ready), 1);
        chk_rdy = 0;
      end
      if (prev_stall)
        chk("stall_hold", {bus.out_valid, cur()},
            {1'b1, prev_tok});
      prev_stall = bus.out_valid && !bus.out_ready;
      prev_tok = cur();
      if (bus.out_valid && bus.out_ready) begin
        total++;
        if (exp_q.size() == 0) begin
          bad++;
          $display("FAIL extra_token: got %h want none",
                   cur());
        end else begin
          tok_t e;
          e = exp_q.pop_front();
          total--;
          chk("token", 32'(cur()), 32'(e));
        end
        if (bus.out_last) chk_rdy = 1;
        popped++;
      end
    end
  end

  // caller sits on a negedge; returns on the negedge after accept
  task automatic send(mat_t m, bit keep);
    int n = 0;
    bit acc;
    bus.in_matrix = m;
    bus.in_valid = 1'b1;
    do begin
      acc = bus.in_ready;
      @(negedge clk);
      n++;
    end while (!acc && n < 2000);
    chk("accept", 32'(acc), 1);
    if (!keep) bus.in_valid = 1'b0;
  endtask

  task automatic drain();
    int n = 0;
    while (exp_q.size() != 0 && n < 3000) begin
      @(negedge clk);
      n++;
    end
    chk("drain", 32'(exp_q.size()), 0);
    repeat (3) @(negedge clk);
  endtask

  task automatic push_eob();
    exp_q.push_back(tk(0, 0, 0, 1, 1));
  endtask

  mat_t m_zero, m_two, m_17, m_63;

  initial begin
    #300000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1);
  end

  initial begin
    int n;
    int target;
    bus.in_valid = 1'b0;
    bus.in_matrix = '0;
    m_zero = '0;
    m_two = '0;
    m_two[0][0] = 11'd5;
    m_two[0][1] = 11'h7FD;
    m_two[1][0] = 11'd2;
    m_17 = '0;
    m_17[2][3] = 11'd7;
    m_63 = '0;
    m_63[7][7] = 11'd1;

    #12;
    chk("rst_out_valid", 32'(bus.out_valid), 0);
    chk("rst_in_ready", 32'(bus.in_ready), 1);
    chk("rst_out_run", 32'(bus.out_run), 0);
    chk("rst_out_level", 32'(bus.out_level), 0);
    chk("rst_flags", {bus.out_dc, bus.out_eob,
        bus.out_last}, 0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    // all-zero block
    exp_q.push_back(tk(0, 0, 1));
    push_eob();
    send(m_zero, 0);
    drain();

    // three leading nonzeros, one negative
    exp_q.push_back(tk(0, 5, 1));
    exp_q.push_back(tk(0, -3));
    exp_q.push_back(tk(0, 2));
    push_eob();
    send(m_two, 0);
    drain();

    // single coefficient at idx 17 -> one ZRL
    exp_q.push_back(tk(0, 0, 1));
    exp_q.push_back(tk(15, 0));
    exp_q.push_back(tk(0, 7));
    push_eob();
    send(m_17, 0);
    drain();

    // idx 63 nonzero -> three ZRL, last on data, no EOB
    exp_q.push_back(tk(0, 0, 1));
    repeat (3) exp_q.push_back(tk(15, 0));
    exp_q.push_back(tk(14, 1, 0, 0, 1));
    send(m_63, 0);
    drain();

    // same block under toggling then random backpressure
    for (int k = 1; k <= 2; k++) begin
      mode = k;
      exp_q.push_back(tk(0, 5, 1));
      exp_q.push_back(tk(0, -3));
      exp_q.push_back(tk(0, 2));
      push_eob();
      send(m_two, 0);
      drain();
    end
    mode = 2;
    exp_q.push_back(tk(0, 0, 1));
    repeat (3) exp_q.push_back(tk(15, 0));
    exp_q.push_back(tk(14, 1, 0, 0, 1));
    send(m_63, 0);
    drain();
    mode = 0;
    repeat (2) @(negedge clk);

    // back-to-back blocks, reset during the second scan
    target = popped + 6;
    exp_q.push_back(tk(0, 5, 1));
    exp_q.push_back(tk(0, -3));
    exp_q.push_back(tk(0, 2));
    push_eob();
    exp_q.push_back(tk(0, 0, 1));
    exp_q.push_back(tk(15, 0));
    exp_q.push_back(tk(0, 7));
    push_eob();
    send(m_two, 1);
    send(m_17, 0);
    n = 0;
    while (popped < target && n < 2000) begin
      @(posedge clk);
      n++;
    end
    chk("reach_scan", 32'(popped >= target), 1);
    @(negedge clk);
    #2;
    rst_n = 1'b0;
    exp_q.delete();
    #1;
    chk("midrst_out_valid", 32'(bus.out_valid), 0);
    chk("midrst_in_ready", 32'(bus.in_ready), 1);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk("post_rst_out_valid", 32'(bus.out_valid), 0);

    exp_q.push_back(tk(0, 0, 1));
    exp_q.push_back(tk(15, 0));
    exp_q.push_back(tk(0, 7));
    push_eob();
    send(m_17, 0);
    drain();
    repeat (5) @(negedge clk);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
